// File: rtl/ps2out.sv
// PS/2 host-to-device transmitter. It sends one command byte to the keyboard
// by driving the shared open-drain clock and data lines through output-enables.
//
// Optional build macro PS2_TX_RETRY_EN: when it is defined, a failed frame is
// retried once with the same byte. The error pulse is issued only if the retry
// also fails.
module ps2out #(
  parameter int INHIBIT_CYCLES = 2516,
  parameter int TIMEOUT_CYCLES = 503040,
  parameter int FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       res,
  input  logic [7:0] data,
  input  logic       send,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       ps2clk_oe,
  output logic       ps2data_oe
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int FLT_W   = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);
  localparam logic [FLT_W-1:0] FLT_ONE  = FLT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_BITS,       // request-to-send (n == 0) and the data/parity/stop bits
    S_ACK,
    S_WAITIDLE
  } state_t;

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       n, n_nxt;
  logic             tx_bit, tx_bit_nxt;
  logic [7:0]       byte_q, byte_nxt;
  logic             par_q, par_nxt;
`ifdef PS2_TX_RETRY_EN
  logic             retried, retried_nxt;
`endif

  logic             ps2clk_p0, ps2clk_p1;
  logic             ps2data_p0, ps2data_p1;
  logic             clk_filt, clk_filt_prev;
  logic [FLT_W-1:0] flt_cnt;
  logic             fall;
  logic             fail;
  logic             tmo;

  // Pin synchronizers and the ps2 clock glitch filter; lines idle high.
  always_ff @(posedge clk) begin
    if (res) begin
      ps2clk_p0     <= 1'b1;
      ps2clk_p1     <= 1'b1;
      ps2data_p0    <= 1'b1;
      ps2data_p1    <= 1'b1;
      clk_filt      <= 1'b1;
      clk_filt_prev <= 1'b1;
      flt_cnt       <= '0;
    end else begin
      ps2clk_p0     <= ps2clk_in;
      ps2clk_p1     <= ps2clk_p0;
      ps2data_p0    <= ps2data_in;
      ps2data_p1    <= ps2data_p0;
      clk_filt_prev <= clk_filt;
      if (ps2clk_p1 == clk_filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_LAST) begin
        clk_filt <= ps2clk_p1;
        flt_cnt  <= '0;
      end else begin
        flt_cnt <= flt_cnt + FLT_ONE;
      end
    end
  end

  assign fall = clk_filt_prev & ~clk_filt;
  assign tmo  = (cnt == TMO_LAST);
  assign busy = (state != S_IDLE);

  // Transmit FSM state and datapath registers.
  always_ff @(posedge clk) begin
    if (res) begin
      state   <= S_IDLE;
      cnt     <= '0;
      n       <= '0;
      tx_bit  <= 1'b0;
      byte_q  <= '0;
      par_q   <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retried <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      n       <= n_nxt;
      tx_bit  <= tx_bit_nxt;
      byte_q  <= byte_nxt;
      par_q   <= par_nxt;
`ifdef PS2_TX_RETRY_EN
      retried <= retried_nxt;
`endif
    end
  end

  // Next-state, line drive and done/error pulses.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    n_nxt       = n;
    tx_bit_nxt  = tx_bit;
    byte_nxt    = byte_q;
    par_nxt     = par_q;
`ifdef PS2_TX_RETRY_EN
    retried_nxt = retried;
`endif
    fail        = 1'b0;
    done        = 1'b0;
    error       = 1'b0;
    ps2clk_oe   = 1'b0;
    ps2data_oe  = 1'b0;

    case (state)
      S_IDLE: begin
`ifdef PS2_TX_RETRY_EN
        retried_nxt = 1'b0;
`endif
        if (send) begin
          byte_nxt  = data;
          par_nxt   = odd_parity(data);
          cnt_nxt   = '0;
          state_nxt = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        ps2clk_oe = 1'b1;
        if (cnt == INH_LAST) begin
          // Start bit goes out while the clock is still held low.
          ps2data_oe = 1'b1;
          cnt_nxt    = '0;
          n_nxt      = '0;
          tx_bit_nxt = 1'b1;
          state_nxt  = S_BITS;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      S_BITS: begin
        ps2data_oe = tx_bit;
        cnt_nxt    = cnt + CNT_ONE;
        if (tmo) begin
          fail = 1'b1;
        end else if (fall) begin
          n_nxt = n + 4'd1;
          if (n < 4'd8) begin
            tx_bit_nxt = ~byte_q[n[2:0]];
          end else if (n == 4'd8) begin
            tx_bit_nxt = ~par_q;
          end else begin
            tx_bit_nxt = 1'b0;
            state_nxt  = S_ACK;
          end
        end
      end
      S_ACK: begin
        cnt_nxt = cnt + CNT_ONE;
        if (tmo) begin
          fail = 1'b1;
        end else if (fall) begin
          if (!ps2data_p1) state_nxt = S_WAITIDLE;
          else             fail      = 1'b1;
        end
      end
      S_WAITIDLE: begin
        cnt_nxt = cnt + CNT_ONE;
        if (tmo) begin
          fail = 1'b1;
        end else if (clk_filt && ps2data_p1) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (fail) begin
      state_nxt = S_IDLE;
`ifdef PS2_TX_RETRY_EN
      if (!retried) begin
        retried_nxt = 1'b1;
        cnt_nxt     = '0;
        state_nxt   = S_INHIBIT;
      end else begin
        error = 1'b1;
      end
`else
      error = 1'b1;
`endif
    end

    // A reset cycle never reports completion.
    if (res) begin
      done  = 1'b0;
      error = 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2out.sv
// Bench for ps2out: a keyboard model on the open-drain lines samples the frame
// on its rising clock edges; expected frames and outcomes come from a
// byte-level model of the PS/2 host-to-device framing rules.
module tb_ps2out;

  localparam int INH = 40;
  localparam int TMO = 1500;
  localparam int FLT = 4;

  logic       clk = 1'b0;
  logic       res;
  logic [7:0] data;
  logic       send;
  logic       busy, done, error;
  logic       ps2clk_in, ps2data_in;
  logic       ps2clk_oe, ps2data_oe;
  logic       dev_clk_low, dev_data_low;

  int tests = 0;
  int fails = 0;

  int  done_cnt = 0, error_cnt = 0, inhibit_runs = 0;
  int  last_inh = 0, inh_run = 0;
  int  cyc = 0, req_cyc = 0, err_cyc = 0;
  bit  mon_en = 1'b0;
  bit  pulse_prev = 1'b0;
  bit  clk_oe_prev = 1'b0;

  always #5 clk = ~clk;

  assign ps2clk_in  = ~(ps2clk_oe  | dev_clk_low);
  assign ps2data_in = ~(ps2data_oe | dev_data_low);

  ps2out #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN    (FLT)
  ) dut (
    .clk       (clk),
    .res       (res),
    .data      (data),
    .send      (send),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .ps2clk_in (ps2clk_in),
    .ps2data_in(ps2data_in),
    .ps2clk_oe (ps2clk_oe),
    .ps2data_oe(ps2data_oe)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Frame as the keyboard sees it: bit 0 = start, 1..8 = d0..d7, 9 = parity, 10 = stop.
  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    ones = 0;
    f    = '0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      if (b[i]) ones++;
    end
    f[0]  = 1'b0;
    f[9]  = ((ones % 2) == 0) ? 1'b1 : 1'b0;
    f[10] = 1'b1;
    return f;
  endfunction

  // Per-cycle monitor: pulse bookkeeping, idle line release, inhibit length.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cyc++;
        check("pulse_excl", 32'(done & error), 32'd0);
        if (!busy) check("idle_lines", 32'({ps2clk_oe, ps2data_oe}), 32'd0);
        if (done || error) check("busy_at_pulse", 32'(busy), 32'd1);
        if (pulse_prev) check("busy_after_pulse", 32'(busy), 32'd0);
        pulse_prev = done | error;
        if (done)  done_cnt++;
        if (error) begin error_cnt++; err_cyc = cyc; end
        if (ps2clk_oe) begin
          inh_run++;
        end else if (clk_oe_prev) begin
          last_inh = inh_run;
          inh_run  = 0;
          inhibit_runs++;
          if (ps2data_oe) req_cyc = cyc;
        end
        clk_oe_prev = ps2clk_oe;
      end
    end
  end

  // Keyboard model: waits for request-to-send, clocks 11 times with half
  // period h, samples data on each rising edge, optionally ACKs on clock 11.
  task automatic dev_frame(input int h, input bit ack, input int glitch_k,
                           input bit send_mid, input int abort_k,
                           output logic [10:0] smp, output bit ok);
    int w;
    smp = '0;
    ok  = 1'b0;
    w   = 0;
    while (!(ps2clk_in === 1'b1 && ps2data_in === 1'b0) && w < 20 * INH + 100) begin
      tick(1);
      w++;
    end
    if (w >= 20 * INH + 100) begin
      fail_now("req_wait");
      return;
    end
    smp[0] = ps2data_in;
    for (int k = 1; k <= 11; k++) begin
      if (k == glitch_k) begin
        tick(5); dev_clk_low = 1'b1; tick(2); dev_clk_low = 1'b0; tick(h - 7);
      end else if (k == 11) begin
        tick(h / 2); dev_data_low = ack; tick(h - h / 2);
      end else if (send_mid && k == 5) begin
        data = 8'h3C; send = 1'b1; tick(1); send = 1'b0; tick(h - 1);
      end else begin
        tick(h);
      end
      dev_clk_low = 1'b1;
      if (k == abort_k) begin
        tick(h / 2);
        res = 1'b1;
        tick(1);
        res = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_clk_oe", 32'(ps2clk_oe), 32'd0);
        check("abort_data_oe", 32'(ps2data_oe), 32'd0);
        dev_clk_low = 1'b0;
        return;
      end
      tick(h);
      dev_clk_low = 1'b0;
      if (k <= 10) smp[k] = ps2data_in;
    end
    tick(5);
    dev_data_low = 1'b0;
    ok = 1'b1;
  endtask

  task automatic run_tx(input logic [7:0] b, input int h, input bit ack,
                        input int glitch_k, input bit send_mid);
    int d0, e0, i0, w, runs;
    logic [10:0] smp, smp2;
    bit ok, ok2;
    d0 = done_cnt; e0 = error_cnt; i0 = inhibit_runs;
    data = b; send = 1'b1; tick(1); send = 1'b0; data = 8'($urandom);
    check("busy_on_accept", 32'(busy), 32'd1);
    dev_frame(h, ack, glitch_k, send_mid, 0, smp, ok);
    if (ok) check("frame", 32'(smp), 32'(exp_frame(b)));
    runs = 1;
`ifdef PS2_TX_RETRY_EN
    if (!ack) begin
      runs = 2;
      dev_frame(h, 1'b0, 0, 1'b0, 0, smp2, ok2);
      if (ok2) check("retry_frame", 32'(smp2), 32'(exp_frame(b)));
    end
`endif
    w = 0;
    while (done_cnt == d0 && error_cnt == e0 && w < TMO + 500) begin
      tick(1);
      w++;
    end
    if (w >= TMO + 500) fail_now("pulse_wait");
    tick(2);
    check("done_count", 32'(done_cnt - d0), ack ? 32'd1 : 32'd0);
    check("error_count", 32'(error_cnt - e0), ack ? 32'd0 : 32'd1);
    check("inhibit_len", 32'(last_inh), 32'(INH));
    check("inhibit_runs", 32'(inhibit_runs - i0), 32'(runs));
    check("busy_end", 32'(busy), 32'd0);
  endtask

  task automatic run_timeout(input logic [7:0] b);
    int d0, e0, i0, w, runs;
    d0 = done_cnt; e0 = error_cnt; i0 = inhibit_runs;
    data = b; send = 1'b1; tick(1); send = 1'b0;
    w = 0;
    while (error_cnt == e0 && w < 3 * (TMO + INH) + 100) begin
      tick(1);
      w++;
    end
    if (w >= 3 * (TMO + INH) + 100) fail_now("timeout_wait");
    runs = 1;
`ifdef PS2_TX_RETRY_EN
    runs = 2;
`endif
    // The counter starts at 0 in the first request cycle; error is the cycle it holds TMO-1.
    check("timeout_cycles", 32'(err_cyc - req_cyc), 32'(TMO - 1));
    check("timeout_error", 32'(error_cnt - e0), 32'd1);
    check("timeout_done", 32'(done_cnt - d0), 32'd0);
    check("timeout_inh_runs", 32'(inhibit_runs - i0), 32'(runs));
    check("timeout_inh_len", 32'(last_inh), 32'(INH));
    tick(2);
    check("timeout_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] f;
    logic [10:0] smp;
    bit ok;
    int d0, e0;

    res = 1'b1; send = 1'b0; data = '0; dev_clk_low = 1'b0; dev_data_low = 1'b0;
    tick(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_clk_oe", 32'(ps2clk_oe), 32'd0);
    check("rst_data_oe", 32'(ps2data_oe), 32'd0);
    res = 1'b0;
    tick(2);
    mon_en = 1'b1;

    // Hand-computed framing pins the model: 0xED -> start 0, 1,0,1,1,0,1,1,1, parity 1, stop 1.
    check("model_ED", 32'(exp_frame(8'hED)), 32'h7DA);
    f = exp_frame(8'h00); check("model_par00", 32'(f[9]), 32'd1);
    f = exp_frame(8'hFF); check("model_parFF", 32'(f[9]), 32'd1);
    f = exp_frame(8'h01); check("model_par01", 32'(f[9]), 32'd0);

    run_tx(8'hED, 25, 1'b1, 0, 1'b0);
    run_tx(8'h00, 22, 1'b1, 0, 1'b0);
    run_tx(8'hFF, 30, 1'b1, 0, 1'b0);
    run_tx(8'h01, 35, 1'b1, 0, 1'b0);

    // Device withholds ACK.
    run_tx(8'h55, 24, 1'b0, 0, 1'b0);

    // Device never clocks.
    run_timeout(8'hF4);

    // Reset during bit 4, then a clean transfer.
    d0 = done_cnt; e0 = error_cnt;
    data = 8'h5A; send = 1'b1; tick(1); send = 1'b0;
    dev_frame(26, 1'b1, 0, 1'b0, 4, smp, ok);
    tick(20);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_no_error", 32'(error_cnt - e0), 32'd0);
    run_tx(8'hA5, 26, 1'b1, 0, 1'b0);

    // Clock glitch before bit 3 and a send while busy.
    run_tx(8'h96, 30, 1'b1, 3, 1'b1);
    d0 = inhibit_runs;
    tick(100);
    check("send_busy_ignored", 32'(inhibit_runs - d0), 32'd0);
    check("send_busy_idle", 32'(busy), 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_tx(8'($urandom), int'($urandom_range(20, 35)), 1'b1, 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
